res_station: RTL and testbench
==============================

# res_station

Out-of-order reservation station receiving entries from the dispatch stage and issuing operand-ready entries to one execution unit. It holds up to DEPTH entries, wakes source operands by snooping the CDB, applies early-branch-recovery (BRB) clean/kill broadcasts, and issues the oldest ready entry each cycle over a valid/ready handshake. One instance is placed per issue queue (int, mud, bra, mem).

## Interface
- DEPTH, 8: entry count, power of two, 2–32.
- PHYS_REG_WIDTH, backend_types value: physical register tag width.
- COB_DEPTH, backend_types value: branch-mask width; tag width is clog2(COB_DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wen  in  1  dispatch write strobe.
- wdata  in  res_entry_t  entry from dispatch; uses prs1/prs2_addr, prs1/prs2_ready and branch_mask.
- full  out  1  all DEPTH slots valid.
- count  out  clog2(DEPTH)+1  occupancy.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_prd  in  PHYS_REG_WIDTH  CDB destination tag.
- brb_broadcast, brb_clean, brb_kill  in  1 each  branch resolution event.
- brb_tag  in  clog2(COB_DEPTH)  resolving branch tag.
- issue_valid  out  1  selected entry is ready.
- issue_ready  in  1  execution unit accepts.
- issue_data  out  res_entry_t  selected entry.

## Operation
- State per slot: valid bit and res_entry_t. Age matrix older[i][j] is set when slot j was allocated before slot i.
- Allocation: on wen && !full, write to the lowest-index slot that was invalid at the start of the cycle. older[new][j] = valid[j] for all j, and older[j][new] is cleared. A slot freed by an issue in the same cycle is not reused until the next cycle. If wen is asserted while full, the write is dropped and an assertion fires.
- Write-time snoop: if cdb_valid and cdb_prd matches the incoming prs1/prs2_addr, the stored ready bit is set.
- Wakeup: each cycle, every valid slot whose prsN_addr equals cdb_prd under cdb_valid sets prsN_ready (registered).
- Ready: valid && prs1_ready && prs2_ready.
- Select: the ready slot with no ready older slot.
  - issue_valid = any ready slot.
  - issue_data = that slot's entry with brb_tag mask bit cleared when brb_broadcast && brb_clean.
- Free: on issue_valid && issue_ready, the selected slot's valid bit clears at the edge.
- BRB clean: clear branch_mask[brb_tag] in all valid slots and in the incoming wdata.
- BRB kill: invalidate every valid slot with branch_mask[brb_tag] set, and drop an incoming write with that bit set.
  - issue_valid is forced low that cycle if the selected entry would be killed.
  - No other older ready entry is substituted in that cycle.
- Simultaneous write, issue, wakeup and clean in one cycle: all four apply independently to their own slots.
- full and count are derived from registered valid bits only. No same-cycle credit is given for a freeing issue.

## Timing
- Reset (async, rst_n low) clears all valid bits and the age matrix. Outputs during reset: full=0, count=0, issue_valid=0, issue_data=0.
- An entry written ready in cycle N is first issuable in cycle N+1.
- A CDB wakeup in cycle N makes the entry issuable in cycle N+1 (registered path).
- issue_data is held stable while issue_valid && !issue_ready, unless a kill or an older entry becoming ready changes the selection. The execution unit treats each cycle independently.
- Throughput: one issue per cycle.
- full rises the cycle after the DEPTH-th write and falls the cycle after the first free.

## Configuration
- RS_CDB_BYPASS_EN defined: the ready computation also ORs in the same-cycle CDB tag match. A slot woken in cycle N issues in cycle N, and issue_data carries the updated ready bits. This lengthens the critical path from cdb_prd to the select logic to issue_valid.
- Not defined: wakeup is registered only; the extra cycle above applies.

## Test plan
- Fill 8 entries, all operands ready, issue_ready=1 → issued in allocation order slots 0..7, full high after write 8, count returns to 0.
- Entry with prs1_addr=5, prs1_ready=0. cdb_valid, cdb_prd=5 in cycle 3 → issue_valid in cycle 4; in cycle 3 when RS_CDB_BYPASS_EN is defined.
- Entries A (older, blocked) and B (ready), then A wakes → B issues first, then A. When both are ready, A issues before B.
- Entries with masks 4'b0010 and 4'b0100. brb_broadcast, kill, tag=1 → first entry removed, count 2→1, second remains issuable.
- brb clean tag=2 in the cycle the entry with mask 4'b0100 issues → issue_data.branch_mask=0 and stored masks cleared.
- rst_n pulsed low mid-cycle with 5 valid entries → issue_valid, full and count drop to 0 immediately and stay 0 until the next write.

Source files
------------

// File: rtl/res_station.sv
// Reservation station: age-matrix oldest-ready select, CDB wakeup, BRB clean/kill.
// Optional RS_CDB_BYPASS_EN: same-cycle CDB match also counts toward ready.
package backend_types;
  localparam int PHYS_REG_WIDTH = 6;
  localparam int COB_DEPTH = 4;

  typedef struct packed {
    logic [7:0]                uop;
    logic [PHYS_REG_WIDTH-1:0] prd;
    logic [PHYS_REG_WIDTH-1:0] prs1_addr;
    logic                      prs1_ready;
    logic [PHYS_REG_WIDTH-1:0] prs2_addr;
    logic                      prs2_ready;
    logic [COB_DEPTH-1:0]      branch_mask;
  } res_entry_t;
endpackage

module res_station #(
  parameter int DEPTH = 8,
  parameter int PHYS_REG_WIDTH = backend_types::PHYS_REG_WIDTH,
  parameter int COB_DEPTH = backend_types::COB_DEPTH,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int IW = $clog2(DEPTH),
  localparam int TW = $clog2(COB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wen,
  input  backend_types::res_entry_t wdata,
  output logic                      full,
  output logic [CW-1:0]             count,
  input  logic                      cdb_valid,
  input  logic [PHYS_REG_WIDTH-1:0] cdb_prd,
  input  logic                      brb_broadcast,
  input  logic                      brb_clean,
  input  logic                      brb_kill,
  input  logic [TW-1:0]             brb_tag,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output backend_types::res_entry_t issue_data
);

  logic [DEPTH-1:0]          valid_q;
  backend_types::res_entry_t ent_q [DEPTH];
  logic [DEPTH-1:0]          older_q [DEPTH];

  logic [DEPTH-1:0] hit1, hit2, r1, r2, rdy, sel;
  backend_types::res_entry_t sel_ent, wr_ent;
  logic [COB_DEPTH-1:0] sel_mask;
  logic [IW-1:0]        free_idx;
  logic                 do_clean, do_kill, kill_sel, fire, wr_en;

  assign do_clean = brb_broadcast && brb_clean;
  assign do_kill  = brb_broadcast && brb_kill;

  always_comb begin
    hit1     = '0;
    hit2     = '0;
    r1       = '0;
    r2       = '0;
    rdy      = '0;
    sel      = '0;
    sel_ent  = '0;
    sel_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = cdb_valid && (ent_q[i].prs1_addr == cdb_prd);
      hit2[i] = cdb_valid && (ent_q[i].prs2_addr == cdb_prd);
`ifdef RS_CDB_BYPASS_EN
      r1[i] = ent_q[i].prs1_ready | hit1[i];
      r2[i] = ent_q[i].prs2_ready | hit2[i];
`else
      r1[i] = ent_q[i].prs1_ready;
      r2[i] = ent_q[i].prs2_ready;
`endif
      rdy[i] = valid_q[i] & r1[i] & r2[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = rdy[i] && !(|(rdy & older_q[i]));
      if (sel[i]) begin
        sel_ent            = ent_q[i];
        sel_ent.prs1_ready = r1[i];
        sel_ent.prs2_ready = r2[i];
        sel_mask           = ent_q[i].branch_mask;
        if (do_clean) sel_ent.branch_mask[brb_tag] = 1'b0;
      end
    end
  end

  assign kill_sel    = do_kill && sel_mask[brb_tag];
  assign issue_valid = (|rdy) && !kill_sel;
  assign issue_data  = sel_ent;
  assign fire        = issue_valid && issue_ready;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IW'(i);
  end

  always_comb begin
    wr_ent = wdata;
    if (cdb_valid && wdata.prs1_addr == cdb_prd) wr_ent.prs1_ready = 1'b1;
    if (cdb_valid && wdata.prs2_addr == cdb_prd) wr_ent.prs2_ready = 1'b1;
    if (do_clean) wr_ent.branch_mask[brb_tag] = 1'b0;
  end

  assign full  = &valid_q;
  assign wr_en = wen && !full && !(do_kill && wdata.branch_mask[brb_tag]);

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++)
      count = count + CW'(valid_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        older_q[i] <= '0;
        ent_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          if (hit1[i]) ent_q[i].prs1_ready <= 1'b1;
          if (hit2[i]) ent_q[i].prs2_ready <= 1'b1;
          if (do_clean) ent_q[i].branch_mask[brb_tag] <= 1'b0;
          if ((do_kill && ent_q[i].branch_mask[brb_tag]) || (fire && sel[i]))
            valid_q[i] <= 1'b0;
        end
      end
      // new slot is younger than every slot valid now; clear stale column
      if (wr_en) begin
        valid_q[free_idx] <= 1'b1;
        ent_q[free_idx]   <= wr_ent;
        older_q[free_idx] <= valid_q;
        for (int j = 0; j < DEPTH; j++)
          if (IW'(j) != free_idx) older_q[j][free_idx] <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_write_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(wen && full)
  );
`endif

endmodule

// File: tb/tb_res_station.sv
// Directed + random bench for res_station against an age-ordered queue model.
// Honours RS_CDB_BYPASS_EN the same way as the design.
module tb_res_station;
  import backend_types::*;

  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic wen;
  res_entry_t wdata;
  logic full;
  logic [CW-1:0] count;
  logic cdb_valid;
  logic [PHYS_REG_WIDTH-1:0] cdb_prd;
  logic brb_broadcast, brb_clean, brb_kill;
  logic [1:0] brb_tag;
  logic issue_valid, issue_ready;
  res_entry_t issue_data;

  int checks = 0;
  int errors = 0;

  res_entry_t mq[$];

  always #5 clk = ~clk;

  res_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_prd(cdb_prd),
    .brb_broadcast(brb_broadcast), .brb_clean(brb_clean),
    .brb_kill(brb_kill), .brb_tag(brb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_data(issue_data)
  );

  function automatic res_entry_t mk(int prd, int a1, bit rd1,
                                    int a2, bit rd2, logic [3:0] m);
    res_entry_t e;
    e = '0;
    e.uop = 8'(prd * 3 + 1);
    e.prd = PHYS_REG_WIDTH'(prd);
    e.prs1_addr = PHYS_REG_WIDTH'(a1);
    e.prs1_ready = rd1;
    e.prs2_addr = PHYS_REG_WIDTH'(a2);
    e.prs2_ready = rd2;
    e.branch_mask = m;
    return e;
  endfunction

  function automatic bit cdb_hit(logic [PHYS_REG_WIDTH-1:0] a);
    return cdb_valid && (a == cdb_prd);
  endfunction

  task automatic idle();
    wen = 0; wdata = '0; cdb_valid = 0; cdb_prd = '0;
    brb_broadcast = 0; brb_clean = 0; brb_kill = 0; brb_tag = '0;
    issue_ready = 0;
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // expected outputs from the age-ordered model for the current inputs
  task automatic check_outputs(output bit ev, output int idx);
    res_entry_t ed;
    bit r1, r2, kill;
    idx = -1;
    ed = '0;
    kill = brb_broadcast && brb_kill;
    foreach (mq[k]) begin
      r1 = mq[k].prs1_ready;
      r2 = mq[k].prs2_ready;
`ifdef RS_CDB_BYPASS_EN
      r1 = r1 | cdb_hit(mq[k].prs1_addr);
      r2 = r2 | cdb_hit(mq[k].prs2_addr);
`endif
      if (idx < 0 && r1 && r2) begin
        idx = k;
        ed = mq[k];
        ed.prs1_ready = r1;
        ed.prs2_ready = r2;
        if (brb_broadcast && brb_clean) ed.branch_mask[brb_tag] = 1'b0;
      end
    end
    ev = (idx >= 0) && !(kill && mq[idx].branch_mask[brb_tag]);
    chk("issue_valid", 64'(issue_valid), 64'(ev));
    chk("issue_data", 64'(issue_data), 64'(ed));
    chk("count", 64'(count), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
  endtask

  task automatic model_update(bit ev, int idx);
    res_entry_t nq[$];
    res_entry_t e;
    bit kill, clean, acc;
    kill = brb_broadcast && brb_kill;
    clean = brb_broadcast && brb_clean;
    acc = wen && mq.size() < DEPTH && !(kill && wdata.branch_mask[brb_tag]);
    foreach (mq[k]) begin
      e = mq[k];
      if (ev && issue_ready && k == idx) continue;
      if (kill && e.branch_mask[brb_tag]) continue;
      if (cdb_hit(e.prs1_addr)) e.prs1_ready = 1'b1;
      if (cdb_hit(e.prs2_addr)) e.prs2_ready = 1'b1;
      if (clean) e.branch_mask[brb_tag] = 1'b0;
      nq.push_back(e);
    end
    if (acc) begin
      e = wdata;
      if (cdb_hit(e.prs1_addr)) e.prs1_ready = 1'b1;
      if (cdb_hit(e.prs2_addr)) e.prs2_ready = 1'b1;
      if (clean) e.branch_mask[brb_tag] = 1'b0;
      nq.push_back(e);
    end
    mq = nq;
  endtask

  // inputs are set just after a rising edge; check mid-cycle, then clock
  task automatic cycle();
    bit ev;
    int idx;
    #2;
    check_outputs(ev, idx);
    model_update(ev, idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst_n = 1;
    cycle();

    // fill with ready entries, then drain in allocation order
    for (int i = 0; i < DEPTH; i++) begin
      wen = 1;
      wdata = mk(10 + i, 1, 1, 2, 1, 4'b0);
      cycle();
    end
    idle();
    cycle();
    issue_ready = 1;
    repeat (DEPTH + 1) cycle();

    // CDB wakeup of a blocked operand
    idle();
    wen = 1;
    wdata = mk(30, 5, 0, 3, 1, 4'b0);
    cycle();
    idle();
    issue_ready = 1;
    cycle();
    cdb_valid = 1; cdb_prd = 5;
    cycle();
    cdb_valid = 0;
    repeat (2) cycle();

    // older blocked A, younger ready B: B first, then A
    idle();
    wen = 1; wdata = mk(31, 9, 0, 3, 1, 4'b0);
    cycle();
    wdata = mk(32, 1, 1, 3, 1, 4'b0);
    cycle();
    idle();
    issue_ready = 1;
    cycle();
    cdb_valid = 1; cdb_prd = 9;
    cycle();
    idle();
    issue_ready = 1;
    repeat (2) cycle();

    // both ready: older issues first
    idle();
    wen = 1; wdata = mk(33, 1, 1, 3, 1, 4'b0);
    cycle();
    wdata = mk(34, 1, 1, 3, 1, 4'b0);
    cycle();
    idle();
    issue_ready = 1;
    repeat (3) cycle();

    // kill tag 1 removes the 0010 entry, 0100 survives
    idle();
    wen = 1; wdata = mk(35, 1, 1, 3, 1, 4'b0010);
    cycle();
    wdata = mk(36, 1, 1, 3, 1, 4'b0100);
    cycle();
    idle();
    brb_broadcast = 1; brb_kill = 1; brb_tag = 2'd1;
    issue_ready = 1;
    cycle();
    idle();
    issue_ready = 1;
    repeat (2) cycle();

    // clean tag 2 while the 0100 entry issues, and on a stored one
    idle();
    wen = 1; wdata = mk(37, 1, 1, 3, 1, 4'b0100);
    cycle();
    wdata = mk(38, 1, 1, 3, 1, 4'b0100);
    cycle();
    idle();
    brb_broadcast = 1; brb_clean = 1; brb_tag = 2'd2;
    issue_ready = 1;
    cycle();
    idle();
    issue_ready = 1;
    repeat (2) cycle();

    // async reset mid-cycle with five entries held
    idle();
    for (int i = 0; i < 5; i++) begin
      wen = 1;
      wdata = mk(40 + i, 1, 1, 2, 1, 4'b0);
      cycle();
    end
    idle();
    #2;
    rst_n = 0;
    #1;
    chk("rst_issue_valid", 64'(issue_valid), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_issue_data", 64'(issue_data), 64'(0));
    mq.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    issue_ready = 1;
    repeat (2) cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      idle();
      wen = ($urandom % 3 != 0) && (mq.size() < DEPTH);
      wdata = mk($urandom_range(0, 60), $urandom_range(0, 7), 1'($urandom),
                 $urandom_range(0, 7), 1'($urandom), 4'($urandom));
      cdb_valid = 1'($urandom);
      cdb_prd = PHYS_REG_WIDTH'($urandom_range(0, 7));
      r = $urandom % 8;
      brb_broadcast = (r < 2);
      brb_kill = (r == 0);
      brb_clean = (r == 1);
      brb_tag = 2'($urandom);
      issue_ready = ($urandom % 4 != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
